// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered sync, blanking,
// line/frame strobes and a free-running frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hs,
  output logic       vs,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] nx;
  logic [9:0] ny;
  logic [10:0] nxe;
  logic [10:0] nye;
  logic       n_hs;
  logic       n_vs;
  logic       n_video;

  // Decode from the next position so the registered syncs line up with x,y.
  always_comb begin
    x_wrap  = (x == H_LAST);
    y_wrap  = (y == V_LAST);
    nx      = x_wrap ? 10'd0 : x + 10'd1;
    ny      = y;
    if (x_wrap) begin
      ny = y_wrap ? 10'd0 : y + 10'd1;
    end
    nxe     = {1'b0, nx};
    nye     = {1'b0, ny};
    n_hs    = (nxe >= HS_BEG && nxe < HS_END) ?
              SYNC_ACTIVE : ~SYNC_ACTIVE;
    n_vs    = (nye >= VS_BEG && nye < VS_END) ?
              SYNC_ACTIVE : ~SYNC_ACTIVE;
    n_video = (nxe < H_VIS) && (nye < V_VIS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      hs          <= ~SYNC_ACTIVE;
      vs          <= ~SYNC_ACTIVE;
      video       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        x           <= nx;
        y           <= ny;
        hs          <= n_hs;
        vs          <= n_vs;
        video       <= n_video;
        line_start  <= x_wrap;
        frame_start <= x_wrap && y_wrap;
        if (x_wrap && y_wrap) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: tick-count reference model on a
// shrunken raster plus a first-line scan of a default-sized instance.
module tb_vga_timing_gen;

  localparam int HV = 6, HF = 1, HSW = 2, HB = 1;
  localparam int VV = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam bit SA = 1'b0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b1;
  logic hs, vs, video, ls, fs;
  logic [9:0] x, y;
  logic [7:0] fc;

  logic rst_d = 1'b1;
  logic en_d = 1'b1;
  logic hs_d, vs_d, video_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [7:0] fc_d;

  int total = 0;
  int bad = 0;
  bit dflt_done = 1'b0;

  always #5 clock = ~clock;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .hs(hs), .vs(vs), .x(x), .y(y), .video(video),
    .line_start(ls), .frame_start(fs), .frame_count(fc)
  );

  vga_timing_gen dflt (
    .clock(clock), .reset(rst_d), .pix_en(en_d),
    .hs(hs_d), .vs(vs_d), .x(x_d), .y(y_d), .video(video_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position is just the enabled-tick count since reset.
  int t = 0;
  bit started = 1'b0;
  bit ticked = 1'b0;
  bit rst_edge = 1'b1;

  always @(posedge clock) begin
    if (reset) begin
      t = 0;
      started = 1'b0;
      ticked = 1'b0;
      rst_edge = 1'b1;
    end else begin
      rst_edge = 1'b0;
      ticked = pix_en;
      if (pix_en) begin
        t++;
        started = 1'b1;
      end
    end
  end

  bit have_prev = 1'b0;
  logic [9:0] px, py;
  logic phs, pvs, pvid;
  logic [7:0] pfc;

  always @(negedge clock) begin
    int ex, ey, eh, ev, evid, efc;
    ex = t % HT;
    ey = (t / HT) % VT;
    eh = (ex >= HV + HF && ex < HV + HF + HSW) ? SA : !SA;
    ev = (ey >= VV + VF && ey < VV + VF + VSW) ? SA : !SA;
    evid = started && ex < HV && ey < VV;
    efc = (t / FT) % 256;
    chk("x", int'(x), ex);
    chk("y", int'(y), ey);
    chk("hs", int'(hs), eh);
    chk("vs", int'(vs), ev);
    chk("video", int'(video), evid);
    chk("line_start", int'(ls), int'(ticked && ex == 0));
    chk("frame_start", int'(fs), int'(ticked && ex == 0 && ey == 0));
    chk("frame_count", int'(fc), efc);
    if (have_prev && !ticked && !rst_edge) begin
      chk("hold", int'({x, y, hs, vs, video, fc}),
          int'({px, py, phs, pvs, pvid, pfc}));
    end
    have_prev = 1'b1;
    {px, py, phs, pvs, pvid, pfc} = {x, y, hs, vs, video, fc};
  end

  // Default 640x480 instance: scan the first full line.
  initial begin
    int hs_lo, first_lo, vid_n, ls_n;
    hs_lo = 0; first_lo = -1; vid_n = 0; ls_n = 0;
    repeat (2) @(negedge clock);
    rst_d = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clock);
      if (hs_d == 1'b0) begin
        if (first_lo < 0) first_lo = int'(x_d);
        hs_lo++;
      end
      vid_n += int'(video_d);
      ls_n += int'(ls_d);
    end
    chk("d_x_wrap", int'(x_d), 0);
    chk("d_y", int'(y_d), 1);
    chk("d_hs_width", hs_lo, 96);
    chk("d_hs_first", first_lo, 656);
    chk("d_video_cnt", vid_n, 640);
    chk("d_line_pulses", ls_n, 1);
    chk("d_frame_start", int'(fs_d), 0);
    dflt_done = 1'b1;
  end

  initial begin
    int ls_n, fs_n, ticks, guard;
    reset = 1'b1;
    pix_en = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    pix_en = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_video", int'(video), 0);
    chk("rst_hs", int'(hs), 1);
    chk("rst_vs", int'(vs), 1);
    chk("rst_fc", int'(fc), 0);

    pix_en = 1'b1;
    @(negedge clock);
    chk("first_x", int'(x), 1);
    chk("first_video", int'(video), 1);

    ls_n = 0; fs_n = 0;
    for (int i = 0; i < HT - 1; i++) begin
      @(negedge clock);
      ls_n += int'(ls);
      fs_n += int'(fs);
      if (i == 4) chk("hs_x6", int'(hs), 1);
      if (i == 5) chk("hs_x7", int'(hs), 0);
    end
    chk("line_x", int'(x), 0);
    chk("line_y", int'(y), 1);
    chk("line_ls", int'(ls), 1);
    chk("line_pulses", ls_n, 1);
    chk("line_fs", fs_n, 0);

    // Enable on every 4th clock for two frames' worth of ticks.
    ls_n = 0; fs_n = 0;
    for (int i = 0; i < 8 * FT; i++) begin
      pix_en = (i % 4 == 0);
      @(negedge clock);
      ls_n += int'(ls);
      fs_n += int'(fs);
    end
    chk("slow_fs", fs_n, 2);
    chk("slow_ls", ls_n, 16);
    chk("slow_fc", int'(fc), 2);

    // Abort mid-frame while vsync is active.
    pix_en = 1'b1;
    guard = 0;
    while (!((t % HT) == 7 && ((t / HT) % VT) == 5) && guard < 4 * FT) begin
      @(negedge clock);
      guard++;
    end
    chk("abort_reach", int'((t % HT) == 7 && ((t / HT) % VT) == 5), 1);
    chk("abort_vs_pre", int'(vs), 0);
    chk("abort_fc_pre", int'(fc), 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    pix_en = 1'b0;
    chk("abort_x", int'(x), 0);
    chk("abort_y", int'(y), 0);
    chk("abort_vs", int'(vs), 1);
    chk("abort_hs", int'(hs), 1);
    chk("abort_fc", int'(fc), 0);
    chk("abort_fs", int'(fs), 0);
    @(negedge clock);
    chk("abort_fs2", int'(fs), 0);

    // Random enables through 256 frames.
    ls_n = 0; fs_n = 0; ticks = 0; guard = 0;
    while (ticks < 256 * FT && guard < 60000) begin
      pix_en = ($urandom_range(3) != 0);
      @(negedge clock);
      guard++;
      if (pix_en) ticks++;
      ls_n += int'(ls);
      if (fs) begin
        fs_n++;
        if (fs_n == 1) begin
          chk("frame1_x", int'(x), 0);
          chk("frame1_y", int'(y), 0);
          chk("frame1_fc", int'(fc), 1);
          chk("frame1_ls", int'(ls), 1);
        end
        if (fs_n == 255) chk("fc_255", int'(fc), 255);
        if (fs_n == 256) chk("fc_wrap", int'(fc), 0);
      end
    end
    chk("rand_ticks", ticks, 256 * FT);
    chk("rand_fs", fs_n, 256);
    chk("rand_ls", ls_n, 256 * VT);
    pix_en = 1'b0;
    repeat (2) @(negedge clock);

    chk("dflt_done", int'(dflt_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 Parameter V_BACK, default 33: vertical back porch, in lines.
REQ-009 Parameter SYNC_ACTIVE, default 0: active level of hs and vs.
REQ-010 Port list (name  direction  width  meaning):
- clock  input  1  single system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- pix_en  input  1  pixel-rate clock enable (25 MHz tick).
- hs  output  1  horizontal sync.
- vs  output  1  vertical sync.
- x  output  10  horizontal count, 0 to H_TOTAL-1.
- y  output  10  vertical count, 0 to V_TOTAL-1.
- video  output  1  high while (x,y) is in the visible area.
- line_start  output  1  one-clock pulse on each wrap of x to 0.
- frame_start  output  1  one-clock pulse on each wrap of (x,y) to (0,0).
- frame_count  output  8  number of frames completed, wraps modulo 256.

Function
REQ-011 Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525); both SHALL be at most 1024.
REQ-012 Counters SHALL change only on clock edges where pix_en=1; with pix_en=0 every output SHALL hold, and the pulse outputs SHALL be 0.
REQ-013 With pix_en=1:
- x SHALL increment by 1.
- At x=H_TOTAL-1, x SHALL wrap to 0 and y SHALL increment.
- At y=V_TOTAL-1 with x=H_TOTAL-1, y SHALL wrap to 0.
REQ-014 All outputs SHALL be registered, and hs, vs and video SHALL correspond to the x,y values present in the same cycle (zero relative latency).
REQ-015 hs SHALL equal SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656 to 751); otherwise hs SHALL equal ~SYNC_ACTIVE.
REQ-016 vs SHALL equal SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490 to 491), independent of x.
REQ-017 video SHALL be 1 iff x < H_VISIBLE and y < V_VISIBLE.
REQ-018 line_start SHALL be 1 for exactly one clock, in the cycle in which x first reads 0 after a wrap.
REQ-019 frame_start SHALL be 1 for exactly one clock, in the cycle in which (x,y) first reads (0,0) after a wrap; line_start SHALL also be 1 in that cycle.
REQ-020 frame_count SHALL increment by 1 in the same cycle that frame_start asserts, wrapping from 255 to 0.
REQ-021 Downstream consumers SHALL gate their colour outputs with video; this block drives no colour data.

Reset
REQ-022 When reset=1 on a clock edge, the block SHALL load, regardless of pix_en:
- x=0, y=0, frame_count=0.
- hs=~SYNC_ACTIVE, vs=~SYNC_ACTIVE.
- video=0, line_start=0, frame_start=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; no pulse SHALL be generated for the aborted frame.
REQ-024 On the first pix_en=1 edge after reset is released, x SHALL become 1 and video SHALL become 1 (position (1,0) is visible).
REQ-025 Reset and pix_en asserted together: reset SHALL take priority.

Verification
REQ-026 Reset, then pix_en=1 continuously for 800 clocks -> x reaches 799 then reads 0; y=1; line_start is high for exactly one clock; frame_start stays 0.
REQ-027 Run 420000 (800x525) enabled clocks after reset -> exactly one frame_start pulse, coincident with (0,0); frame_count=1; exactly 525 line_start pulses.
REQ-028 Scan one full line -> hs=0 exactly for x=656 to 751 (96 cycles); video=1 exactly for x=0 to 639 while y<480; video=0 for every x while y=480.
REQ-029 pix_en=1 for every 4th clock -> all outputs are frozen for 3 clocks out of 4; pulses are one clock wide; the period in enabled ticks matches REQ-027.
REQ-030 Reset asserted at (x=700, y=491) with vs active -> next clock reads x=0, y=0, vs=1, hs=1, frame_count=0; no frame_start pulse.
REQ-031 Force 256 frames -> frame_count wraps from 255 to 0 coincident with the 256th frame_start.
